// File: rtl/mixer_pkg.sv
// Shared types for the serial voice mixer and the blocks built around it.
package mixer_pkg;
  localparam int DEFAULT_AUDIO_WIDTH = 24;

  typedef logic signed [DEFAULT_AUDIO_WIDTH-1:0] audio_t;

  typedef enum logic {
    MIX_SUM = 1'b0,
    MIX_AVG = 1'b1
  } mix_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINAL  = 2'd2,
    OUTPUT = 2'd3
  } mixer_state_t;
endpackage

// File: rtl/mix_saturate.sv
// Signed clamp from IN_WIDTH down to OUT_WIDTH bits, flagging when the value was altered.
module mix_saturate #(
  parameter int IN_WIDTH  = 27,
  parameter int OUT_WIDTH = 24
) (
  input  logic [IN_WIDTH-1:0]  i_value,
  output logic [OUT_WIDTH-1:0] o_value,
  output logic                 o_clipped
);
  logic w_fits;

  // Value is representable when every bit above the output sign bit copies the input sign.
  assign w_fits = (i_value[IN_WIDTH-1:OUT_WIDTH-1] ==
                   {(IN_WIDTH-OUT_WIDTH+1){i_value[IN_WIDTH-1]}});

  always_comb begin
    o_clipped = ~w_fits;
    if (w_fits)
      o_value = i_value[OUT_WIDTH-1:0];
    else if (i_value[IN_WIDTH-1])
      o_value = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      o_value = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
endmodule

// File: rtl/serial_voice_mixer.sv
// Time-multiplexed voice mixer: one enabled voice accumulated per clock, then
// saturated or normalised into a valid/ready output register.
module serial_voice_mixer
  import mixer_pkg::*;
#(
  parameter int AUDIO_WIDTH = DEFAULT_AUDIO_WIDTH,
  parameter int N_VOICES    = 4
) (
  input  logic                                  clock,
  input  logic                                  reset_l,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_VOICES-1:0][AUDIO_WIDTH-1:0]  voices,
  input  logic [N_VOICES-1:0]                   voice_enable,
  input  logic                                  mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [AUDIO_WIDTH-1:0]                audio_out,
  output logic                                  clipped,
  output logic                                  overrun,
  input  logic                                  clear_overrun
);
  localparam int SHIFT     = $clog2(N_VOICES);
  localparam int IDX_WIDTH = (SHIFT > 1) ? SHIFT : 1;
  localparam int ACC_WIDTH = AUDIO_WIDTH + SHIFT + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_VOICES - 1);

  mixer_state_t                          r_state;
  mixer_state_t                          w_next_state;
  logic [N_VOICES-1:0][AUDIO_WIDTH-1:0]  r_voices;
  logic [N_VOICES-1:0]                   r_enable;
  mix_mode_t                             r_mode;
  logic signed [ACC_WIDTH-1:0]           r_acc;
  logic [IDX_WIDTH-1:0]                  r_idx;
  logic [AUDIO_WIDTH-1:0]                r_audio_out;
  logic                                  r_clipped;
  logic                                  r_out_valid;
  logic                                  r_overrun;

  logic [AUDIO_WIDTH-1:0]                w_voice;
  logic signed [ACC_WIDTH-1:0]           w_addend;
  logic signed [ACC_WIDTH-1:0]           w_pre_clamp;
  logic [AUDIO_WIDTH-1:0]                w_sat_value;
  logic                                  w_sat_clipped;

  assign w_voice     = r_voices[r_idx];
  assign w_addend    = r_enable[r_idx] ?
                       {{(ACC_WIDTH-AUDIO_WIDTH){w_voice[AUDIO_WIDTH-1]}}, w_voice} : '0;
  assign w_pre_clamp = (r_mode == MIX_AVG) ? (r_acc >>> SHIFT) : r_acc;

  mix_saturate #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (AUDIO_WIDTH)
  ) u_saturate (
    .i_value   (w_pre_clamp),
    .o_value   (w_sat_value),
    .o_clipped (w_sat_clipped)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)           w_next_state = ACCUM;
      ACCUM:   if (r_idx == LAST_IDX)  w_next_state = FINAL;
      FINAL:                           w_next_state = OUTPUT;
      OUTPUT:  if (out_ready)          w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_voices    <= '0;
      r_enable    <= '0;
      r_mode      <= MIX_SUM;
      r_acc       <= '0;
      r_idx       <= '0;
      r_audio_out <= '0;
      r_clipped   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_voices <= voices;
          r_enable <= voice_enable;
          r_mode   <= mix_mode_t'(mode);
          r_acc    <= '0;
          r_idx    <= '0;
        end
        ACCUM: begin
          r_acc <= r_acc + w_addend;
          r_idx <= r_idx + 1'b1;
        end
        FINAL: begin
          r_audio_out <= w_sat_value;
          r_clipped   <= w_sat_clipped;
          r_out_valid <= 1'b1;
        end
        OUTPUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // A new drop takes priority over a simultaneous clear so no event is lost.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)                   r_overrun <= 1'b0;
    else if (in_valid && !in_ready) r_overrun <= 1'b1;
    else if (clear_overrun)         r_overrun <= 1'b0;
  end

  assign out_valid = r_out_valid;
  assign audio_out = r_audio_out;
  assign clipped   = r_clipped;
  assign overrun   = r_overrun;
endmodule
